// File: rtl/versatile_fifo_sc_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : versatile_fifo_sc_mc_if
// Brief    : Channel-steered write/read port bundle of the multi-channel FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface versatile_fifo_sc_mc_if #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 4,
    parameter int CH_WIDTH   = 1
);
    localparam int NR_OF_CH = 1 << CH_WIDTH;

    logic [DATA_WIDTH-1:0]              d;
    logic                               wr;
    logic [CH_WIDTH-1:0]                wr_ch;
    logic                               rd;
    logic [CH_WIDTH-1:0]                rd_ch;
    logic                               err_clr;
    logic [DATA_WIDTH-1:0]              q;
    logic                               q_valid;
    logic [CH_WIDTH-1:0]                q_ch;
    logic [NR_OF_CH-1:0]                fifo_full;
    logic [NR_OF_CH-1:0]                fifo_empty;
    logic [NR_OF_CH-1:0]                almost_full;
    logic [NR_OF_CH-1:0]                almost_empty;
    logic [NR_OF_CH*(ADDR_WIDTH+1)-1:0] fill_lvl;
    logic [NR_OF_CH-1:0]                overflow;
    logic [NR_OF_CH-1:0]                underflow;

    modport master (
        output d, wr, wr_ch, rd, rd_ch, err_clr,
        input  q, q_valid, q_ch, fifo_full, fifo_empty, almost_full,
               almost_empty, fill_lvl, overflow, underflow
    );

    modport slave (
        input  d, wr, wr_ch, rd, rd_ch, err_clr,
        output q, q_valid, q_ch, fifo_full, fifo_empty, almost_full,
               almost_empty, fill_lvl, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/versatile_fifo_sc_mc.sv
`default_nettype none
// ============================================================================
// Module   : versatile_fifo_sc_mc
// Brief    : Single-clock FIFO with NR_OF_CH channels sharing one dual-port RAM.
// Revision : 1.0 - initial release
// ============================================================================
module versatile_fifo_sc_mc #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 4,
    parameter int CH_WIDTH   = 1,
    parameter int AFULL_LVL  = 12,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    versatile_fifo_sc_mc_if.slave bus
);
    localparam int NR_OF_CH = 1 << CH_WIDTH;
    localparam int DEPTH    = NR_OF_CH << ADDR_WIDTH;
    localparam int PW       = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AFULL_THR  = PW'(AFULL_LVL);
    localparam logic [PW-1:0] AEMPTY_THR = PW'(AEMPTY_LVL);

    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
    logic [PW-1:0]          w_wptr [NR_OF_CH];
    logic [PW-1:0]          w_rptr [NR_OF_CH];
    logic [NR_OF_CH-1:0]    w_full;
    logic [NR_OF_CH-1:0]    w_empty;
    logic [NR_OF_CH-1:0]    w_afull;
    logic [NR_OF_CH-1:0]    w_aempty;
    logic [NR_OF_CH-1:0]    w_ovf;
    logic [NR_OF_CH-1:0]    w_udf;
    logic [NR_OF_CH*PW-1:0] w_fill_lvl;
    logic                   w_wr_ok;
    logic                   w_rd_ok;
    logic [PW-1:0]          w_wptr_sel;
    logic [PW-1:0]          w_rptr_sel;
    logic [DATA_WIDTH-1:0]  r_q;
    logic                   r_q_valid;
    logic [CH_WIDTH-1:0]    r_q_ch;

    // Acceptance uses the flags of the registered pointers, so a write into
    // an empty channel is never visible to a read in the same cycle.
    assign w_wr_ok    = bus.wr && !w_full[bus.wr_ch];
    assign w_rd_ok    = bus.rd && !w_empty[bus.rd_ch];
    assign w_wptr_sel = w_wptr[bus.wr_ch];
    assign w_rptr_sel = w_rptr[bus.rd_ch];

    for (genvar c = 0; c < NR_OF_CH; c++) begin : g_ch
        logic [PW-1:0] r_wptr;
        logic [PW-1:0] r_rptr;
        logic          r_ovf;
        logic          r_udf;
        logic [PW-1:0] w_fill;
        logic          w_wr_hit;
        logic          w_rd_hit;

        assign w_wr_hit = bus.wr && (bus.wr_ch == CH_WIDTH'(c));
        assign w_rd_hit = bus.rd && (bus.rd_ch == CH_WIDTH'(c));
        assign w_fill   = r_wptr - r_rptr;

        assign w_wptr[c]   = r_wptr;
        assign w_rptr[c]   = r_rptr;
        assign w_empty[c]  = (r_wptr == r_rptr);
        assign w_full[c]   = (r_wptr[PW-1] != r_rptr[PW-1]) &&
                             (r_wptr[PW-2:0] == r_rptr[PW-2:0]);
        assign w_afull[c]  = (w_fill >= AFULL_THR);
        assign w_aempty[c] = (w_fill <= AEMPTY_THR);
        assign w_ovf[c]    = r_ovf;
        assign w_udf[c]    = r_udf;
        assign w_fill_lvl[c*PW +: PW] = w_fill;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_ovf  <= 1'b0;
                r_udf  <= 1'b0;
            end else begin
                if (w_wr_hit && !w_full[c]) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_rd_hit && !w_empty[c]) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                // A refusal in the clearing cycle keeps its flag set.
                r_ovf <= (r_ovf && !bus.err_clr) || (w_wr_hit && w_full[c]);
                r_udf <= (r_udf && !bus.err_clr) || (w_rd_hit && w_empty[c]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[{bus.wr_ch, w_wptr_sel[PW-2:0]}] <= bus.d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q       <= '0;
            r_q_valid <= 1'b0;
            r_q_ch    <= '0;
        end else begin
            r_q_valid <= w_rd_ok;
            if (w_rd_ok) begin
                r_q    <= r_mem[{bus.rd_ch, w_rptr_sel[PW-2:0]}];
                r_q_ch <= bus.rd_ch;
            end
        end
    end

    assign bus.q            = r_q;
    assign bus.q_valid      = r_q_valid;
    assign bus.q_ch         = r_q_ch;
    assign bus.fifo_full    = w_full;
    assign bus.fifo_empty   = w_empty;
    assign bus.almost_full  = w_afull;
    assign bus.almost_empty = w_aempty;
    assign bus.fill_lvl     = w_fill_lvl;
    assign bus.overflow     = w_ovf;
    assign bus.underflow    = w_udf;
endmodule
`default_nettype wire

// File: tb/tb_versatile_fifo_sc_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_versatile_fifo_sc_mc
// Brief    : Directed and random stimulus against a per-channel queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_versatile_fifo_sc_mc;
    localparam int DW    = 18;
    localparam int AW    = 4;
    localparam int CW    = 1;
    localparam int NCH   = 2;
    localparam int SLOTS = 16;

    logic clk;
    logic rst;

    versatile_fifo_sc_mc_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CH_WIDTH(CW)) bus();

    versatile_fifo_sc_mc #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CH_WIDTH(CW),
        .AFULL_LVL(12), .AEMPTY_LVL(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a circular word store per channel tracked by head and count.
    logic [DW-1:0] m_data [NCH][SLOTS];
    int            m_head [NCH];
    int            m_cnt  [NCH];
    bit            m_ovf  [NCH];
    bit            m_udf  [NCH];
    logic [DW-1:0] e_q;
    bit            e_qv;
    int            e_qch;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_head[c] = 0;
            m_cnt[c]  = 0;
            m_ovf[c]  = 0;
            m_udf[c]  = 0;
        end
        e_q   = '0;
        e_qv  = 0;
        e_qch = 0;
    endtask

    task automatic model_step(bit w, int wc, logic [DW-1:0] dd, bit r, int rc, bit clr);
        bit wok;
        bit rok;
        wok = w && (m_cnt[wc] < SLOTS);
        rok = r && (m_cnt[rc] > 0);
        if (clr) begin
            for (int c = 0; c < NCH; c++) begin
                m_ovf[c] = 0;
                m_udf[c] = 0;
            end
        end
        if (w && !wok) m_ovf[wc] = 1;
        if (r && !rok) m_udf[rc] = 1;
        e_qv = rok;
        if (rok) begin
            e_q        = m_data[rc][m_head[rc]];
            e_qch      = rc;
            m_head[rc] = (m_head[rc] + 1) % SLOTS;
            m_cnt[rc]  = m_cnt[rc] - 1;
        end
        if (wok) begin
            m_data[wc][(m_head[wc] + m_cnt[wc]) % SLOTS] = dd;
            m_cnt[wc] = m_cnt[wc] + 1;
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("fill_lvl[%0d]", c), 32'(bus.fill_lvl[c*(AW+1) +: (AW+1)]), 32'(m_cnt[c]));
            chk($sformatf("fifo_full[%0d]", c), 32'(bus.fifo_full[c]), 32'(m_cnt[c] == SLOTS));
            chk($sformatf("fifo_empty[%0d]", c), 32'(bus.fifo_empty[c]), 32'(m_cnt[c] == 0));
            chk($sformatf("almost_full[%0d]", c), 32'(bus.almost_full[c]), 32'(m_cnt[c] >= 12));
            chk($sformatf("almost_empty[%0d]", c), 32'(bus.almost_empty[c]), 32'(m_cnt[c] <= 2));
            chk($sformatf("overflow[%0d]", c), 32'(bus.overflow[c]), 32'(m_ovf[c]));
            chk($sformatf("underflow[%0d]", c), 32'(bus.underflow[c]), 32'(m_udf[c]));
        end
        chk("q_valid", 32'(bus.q_valid), 32'(e_qv));
        chk("q", 32'(bus.q), 32'(e_q));
        if (e_qv) chk("q_ch", 32'(bus.q_ch), 32'(e_qch));
    endtask

    // Inputs change on the falling edge; outputs are checked on the next falling edge.
    task automatic step(bit w, int wc, logic [DW-1:0] dd, bit r, int rc, bit clr);
        bus.wr      = w;
        bus.wr_ch   = CW'(wc);
        bus.d       = dd;
        bus.rd      = r;
        bus.rd_ch   = CW'(rc);
        bus.err_clr = clr;
        @(posedge clk);
        model_step(w, wc, dd, r, rc, clr);
        @(negedge clk);
        bus.wr      = 1'b0;
        bus.rd      = 1'b0;
        bus.err_clr = 1'b0;
        check_all();
    endtask

    task automatic random_phase(int cycles, int wr_pct, int rd_pct);
        for (int i = 0; i < cycles; i++) begin
            step(($urandom_range(99) < wr_pct), int'($urandom_range(NCH-1)), DW'($urandom),
                 ($urandom_range(99) < rd_pct), int'($urandom_range(NCH-1)),
                 ($urandom_range(15) == 0));
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.d       = '0;
        bus.wr      = 1'b0;
        bus.wr_ch   = '0;
        bus.rd      = 1'b0;
        bus.rd_ch   = '0;
        bus.err_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_all();

        // Fill channel 0, then one refused write and an error clear.
        for (int i = 1; i <= 16; i++) step(1, 0, DW'(i), 0, 0, 0);
        step(1, 0, DW'(17), 0, 0, 0);
        step(0, 0, '0, 0, 0, 1);

        // Drain channel 0 in order, then one refused read.
        for (int i = 0; i < 16; i++) step(0, 0, '0, 1, 0, 0);
        step(0, 0, '0, 1, 0, 0);
        step(0, 0, '0, 0, 0, 1);

        // Cross-channel independence.
        for (int i = 0; i < 3; i++) step(1, 0, DW'(18'h100 + i), 0, 0, 0);
        step(1, 1, DW'(18'h0A5), 1, 0, 0);

        // Empty channel: no fall-through, then wrap at a steady fill of 8.
        step(0, 0, '0, 1, 1, 0);
        step(1, 1, DW'(18'h0B1), 1, 1, 0);
        for (int i = 0; i < 7; i++) step(1, 1, DW'(18'h0C0 + i), 0, 0, 0);
        for (int i = 0; i < 40; i++) step(1, 1, DW'(18'h200 + i), 1, 1, 0);

        // Mid-stream asynchronous reset with channel 0 holding 5 words.
        for (int i = 0; i < 3; i++) step(1, 0, DW'(18'h300 + i), 0, 0, 0);
        chk("fill0_before_reset", 32'(bus.fill_lvl[AW:0]), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        check_all();

        random_phase(150, 80, 30);
        random_phase(150, 30, 80);
        random_phase(200, 55, 55);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
